potential_update_scheduler: RTL and testbench

POTENTIAL_UPDATE_SCHEDULER -- requirements
Module: potential_update_scheduler

---
 rtl/potential_update_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_potential_update_scheduler.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/potential_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : potential_update_scheduler
// Description : Time-multiplexes one combinational floating-point potential
//               adder across NUM_NEURONS neurons. Accepts weighted spike
//               events, presents operands to the adder, waits a fixed settle
//               window, then commits the result and spike flag per neuron.
// Revision    : 1.0 - initial release
// ============================================================================
module potential_update_scheduler #(
  parameter int NUM_NEURONS   = 4,
  parameter int ID_W          = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ts_start,
  input  logic                   ts_end,
  input  logic                   ev_valid,
  output logic                   ev_ready,
  input  logic [ID_W-1:0]        ev_neuron_id,
  input  logic [31:0]            ev_weight,
  output logic [31:0]            add_weight,
  output logic [31:0]            add_potential,
  output logic                   add_clear,
  input  logic [31:0]            add_final_potential,
  input  logic                   add_spike,
  output logic [NUM_NEURONS-1:0] spike_vec,
  output logic                   ts_done,
  output logic                   busy
);

  // Settle counter holds SETTLE_CYCLES-1 down to 0; width never below 1 bit.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_EV = 3'd1,
    S_SETTLE  = 3'd2,
    S_WB      = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                          r_state;
  state_t                          w_next_state;

  logic [NUM_NEURONS-1:0][31:0]    r_pot;
  logic [NUM_NEURONS-1:0]          r_spike_vec;
  logic [ID_W-1:0]                 r_id;
  logic                            r_id_hit;
  logic [31:0]                     r_weight;
  logic [31:0]                     r_op_pot;
  logic [CNT_W-1:0]                r_cnt;
  logic                            r_end_pending;

  logic [31:0]                     w_sel_pot;
  logic                            w_id_hit;
  logic                            w_accept;

  assign w_accept      = (r_state == S_WAIT_EV) && ev_valid;
  assign add_weight    = r_weight;
  assign add_potential = r_op_pot;
  assign spike_vec     = r_spike_vec;

  // Select the stored potential of the offered target; out-of-range ids miss.
  always_comb begin
    w_sel_pot = '0;
    w_id_hit  = 1'b0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (ev_neuron_id == ID_W'(i)) begin
        w_sel_pot = r_pot[i];
        w_id_hit  = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and control outputs.
  always_comb begin
    w_next_state = r_state;
    add_clear    = 1'b0;
    ev_ready     = 1'b0;
    ts_done      = 1'b0;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (ts_start) begin
          // Gated with rst_n so the clear never fires while reset is held.
          add_clear    = rst_n;
          w_next_state = S_WAIT_EV;
        end
      end
      S_WAIT_EV: begin
        ev_ready = 1'b1;
        // A pending event always wins over end-of-timestep.
        if (ev_valid) begin
          w_next_state = S_SETTLE;
        end else if (r_end_pending || ts_end) begin
          w_next_state = S_DONE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_next_state = S_WB;
        end
      end
      S_WB: begin
        w_next_state = S_WAIT_EV;
      end
      S_DONE: begin
        ts_done      = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Latch the accepted event and hold adder operands stable until writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id     <= '0;
      r_id_hit <= 1'b0;
      r_weight <= '0;
      r_op_pot <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_id     <= ev_neuron_id;
        r_id_hit <= w_id_hit;
        r_weight <= ev_weight;
        r_op_pot <= w_sel_pot;
        r_cnt    <= C_CNT_INIT;
      end else if (r_state == S_SETTLE) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end else if (r_state == S_DONE) begin
        // Operands read as zero once the block returns to idle.
        r_weight <= '0;
        r_op_pot <= '0;
      end
    end
  end

  // Remember an end-of-timestep request seen while an event is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_end_pending <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (ts_start) begin
        r_end_pending <= 1'b0;
      end
    end else if (ts_end) begin
      r_end_pending <= 1'b1;
    end
  end

  // Potential file: writeback commits the adder result for in-range targets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pot <= '0;
    end else if ((r_state == S_WB) && r_id_hit) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (r_id == ID_W'(i)) begin
          r_pot[i] <= add_final_potential;
        end
      end
    end
  end

  // Spike flags: cleared at timestep start, sticky-OR on each writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spike_vec <= '0;
    end else if ((r_state == S_IDLE) && ts_start) begin
      r_spike_vec <= '0;
    end else if ((r_state == S_WB) && r_id_hit) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (r_id == ID_W'(i)) begin
          r_spike_vec[i] <= r_spike_vec[i] | add_spike;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_potential_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_potential_update_scheduler
// Description : Scoreboard bench for potential_update_scheduler with a
//               behavioural adder (threshold 1.0, reset by subtraction) and a
//               fixed-point reference model of neuron potentials and spikes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_potential_update_scheduler;

  localparam int NUM    = 3;
  localparam int IDW    = 2;
  localparam int SETTLE = 2;
  localparam int THR    = 256;  // 1.0 in units of 1/256

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ts_start;
  logic            ts_end;
  logic            ev_valid;
  logic            ev_ready;
  logic [IDW-1:0]  ev_neuron_id;
  logic [31:0]     ev_weight;
  logic [31:0]     add_weight;
  logic [31:0]     add_potential;
  logic            add_clear;
  logic [31:0]     add_final_potential;
  logic            add_spike;
  logic [NUM-1:0]  spike_vec;
  logic            ts_done;
  logic            busy;

  potential_update_scheduler #(
    .NUM_NEURONS   (NUM),
    .ID_W          (IDW),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ts_start            (ts_start),
    .ts_end              (ts_end),
    .ev_valid            (ev_valid),
    .ev_ready            (ev_ready),
    .ev_neuron_id        (ev_neuron_id),
    .ev_weight           (ev_weight),
    .add_weight          (add_weight),
    .add_potential       (add_potential),
    .add_clear           (add_clear),
    .add_final_potential (add_final_potential),
    .add_spike           (add_spike),
    .spike_vec           (spike_vec),
    .ts_done             (ts_done),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  // Positive float -> fixed point in 1/256 units (exact for the values used).
  function automatic int f2fix(input logic [31:0] b);
    int m;
    int sh;
    if (b[30:0] == 31'd0) return 0;
    m  = int'({1'b1, b[22:0]});
    sh = 142 - int'(b[30:23]);
    if (sh <= 0) return m;
    if (sh >= 31) return 0;
    return m >>> sh;
  endfunction

  // Fixed point (1/256 units) -> IEEE-754 single.
  function automatic logic [31:0] fix2f(input int n);
    int p;
    logic [31:0] sh;
    if (n <= 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 31; i++) if (n[i]) p = i;
    sh = 32'(n) << (23 - p);
    return {1'b0, 8'(p + 119), sh[22:0]};
  endfunction

  // Behavioural adder: sum, spike at >= 1.0, subtract threshold on spike.
  int stub_sum;
  always_comb begin
    stub_sum            = f2fix(add_potential) + f2fix(add_weight);
    add_spike           = (stub_sum >= THR);
    add_final_potential = fix2f(add_spike ? stub_sum - THR : stub_sum);
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          is_done;
    logic [31:0] w;
    logic [31:0] p;
    bit          chk_p;
    logic [NUM-1:0] spk;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  int             m_pot [4];
  logic [NUM-1:0] m_spk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pot[i] = 0;
    m_spk = '0;
  endtask

  task automatic push_done();
    sbq.push_back(exp_t'{1'b1, 32'd0, 32'd0, 1'b0, m_spk});
  endtask

  // ---------------- monitor ----------------
  bit   hs_pend   = 0;
  bit   gap_on    = 0;
  int   gap       = 0;
  bit   prev_done = 0;
  exp_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      hs_pend   = 0;
      gap_on    = 0;
      prev_done = 0;
    end else begin
      if (hs_pend) begin
        hs_pend = 0;
        if (sbq.size() == 0) begin
          chk("sb_underflow_ev", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("sb_kind_ev", {31'd0, e.is_done}, 32'd0);
          chk("add_weight", add_weight, e.w);
          if (e.chk_p) chk("add_potential", add_potential, e.p);
          chk("busy_in_settle", {31'd0, busy}, 32'd1);
        end
      end
      if (gap_on) begin
        if (ev_ready) begin
          chk("ready_gap", gap, SETTLE + 1);
          gap_on = 0;
        end else if (gap > 20) begin
          chk("ready_gap_timeout", gap, SETTLE + 1);
          gap_on = 0;
        end else begin
          gap++;
        end
      end
      if (ev_valid && ev_ready) begin
        hs_pend = 1;
        gap_on  = 1;
        gap     = 0;
      end
      if (ts_done) begin
        chk("ts_done_width", {31'd0, prev_done}, 32'd0);
        if (sbq.size() == 0) begin
          chk("sb_underflow_done", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("sb_kind_done", {31'd0, e.is_done}, 32'd1);
          chk("spike_vec_at_done", 32'(spike_vec), 32'(e.spk));
        end
        done_cnt++;
      end
      prev_done = ts_done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 60) begin
      tick();
      g++;
    end
    if (busy) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic start_ts();
    wait_idle();
    ts_start = 1'b1;
    @(negedge clk);
    chk("add_clear_pulse", {31'd0, add_clear}, 32'd1);
    tick();
    ts_start = 1'b0;
    m_spk    = '0;
    @(negedge clk);
    chk("add_clear_one_cycle", {31'd0, add_clear}, 32'd0);
    chk("ready_after_start", {31'd0, ev_ready}, 32'd1);
    chk("spike_vec_cleared", 32'(spike_vec), 32'd0);
    tick();
  endtask

  // Issue one event (weight in 1/256 units) and update the reference model.
  task automatic send_ev(input int id, input int units, input bit with_end);
    int          g;
    int          s;
    logic [31:0] wb;
    wb = fix2f(units);
    if (id < NUM) begin
      sbq.push_back(exp_t'{1'b0, wb, fix2f(m_pot[id]), 1'b1, '0});
      s = m_pot[id] + units;
      if (s >= THR) begin
        m_spk[id] = 1'b1;
        s = s - THR;
      end
      m_pot[id] = s;
    end else begin
      sbq.push_back(exp_t'{1'b0, wb, 32'd0, 1'b0, '0});
    end
    if (with_end) push_done();
    ev_valid     = 1'b1;
    ev_neuron_id = IDW'(id);
    ev_weight    = wb;
    ts_end       = with_end;
    g = 0;
    while (!ev_ready && g < 40) begin
      tick();
      g++;
    end
    if (!ev_ready) chk("handshake_timeout", 32'd1, 32'd0);
    tick();
    ev_valid = 1'b0;
    ts_end   = 1'b0;
  endtask

  task automatic end_ts();
    push_done();
    ts_end = 1'b1;
    tick();
    ts_end = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int g;
    g = 0;
    while (done_cnt < target && g < 60) begin
      tick();
      g++;
    end
    if (done_cnt < target) begin
      chk("ts_done_timeout", 32'(done_cnt), 32'(target));
    end else begin
      chk("idle_after_done", {31'd0, busy}, 32'd0);
      chk("idle_add_weight", add_weight, 32'd0);
      chk("idle_add_potential", add_potential, 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ev_ready"}, {31'd0, ev_ready}, 32'd0);
    chk({tag, "_ts_done"}, {31'd0, ts_done}, 32'd0);
    chk({tag, "_add_clear"}, {31'd0, add_clear}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_add_weight"}, add_weight, 32'd0);
    chk({tag, "_add_potential"}, add_potential, 32'd0);
    chk({tag, "_spike_vec"}, 32'(spike_vec), 32'd0);
  endtask

  initial begin
    int n;
    int dc;
    bit we;
    rst_n        = 1'b0;
    ts_start     = 1'b0;
    ts_end       = 1'b0;
    ev_valid     = 1'b0;
    ev_neuron_id = '0;
    ev_weight    = '0;
    model_reset();
    dc = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Single sub-threshold event, then separate ts_end.
    start_ts();
    send_ev(1, 192, 1'b0);
    end_ts();
    dc++;
    wait_done(dc);

    // Accumulation into neuron 1 crosses threshold and spikes.
    start_ts();
    send_ev(1, 192, 1'b0);
    send_ev(1, 64, 1'b0);
    end_ts();
    dc++;
    wait_done(dc);

    // Event and ts_end in the same cycle: event processed before done.
    start_ts();
    send_ev(2, 128, 1'b1);
    dc++;
    wait_done(dc);

    // Out-of-range id and ts_start while busy.
    start_ts();
    send_ev(0, 224, 1'b0);
    send_ev(0, 224, 1'b0);
    send_ev(3, 160, 1'b0);
    ts_start = 1'b1;
    @(negedge clk);
    chk("ts_start_ignored_clear", {31'd0, add_clear}, 32'd0);
    chk("ts_start_ignored_busy", {31'd0, busy}, 32'd1);
    tick();
    ts_start = 1'b0;
    send_ev(1, 32, 1'b0);
    end_ts();
    dc++;
    wait_done(dc);

    // Randomized timesteps.
    for (int t = 0; t < 8; t++) begin
      start_ts();
      n = $urandom_range(3, 9);
      for (int j = 0; j < n; j++) begin
        we = (j == n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        send_ev($urandom_range(0, 3), 32 * $urandom_range(1, 7), we);
        if (j == n - 1 && !we) end_ts();
      end
      dc++;
      wait_done(dc);
    end

    // Reset asserted during SETTLE discards the event.
    start_ts();
    send_ev(0, 96, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("needs_ts_start_ready", {31'd0, ev_ready}, 32'd0);
    chk("needs_ts_start_busy", {31'd0, busy}, 32'd0);
    start_ts();
    send_ev(0, 96, 1'b0);
    send_ev(0, 224, 1'b0);
    end_ts();
    dc++;
    wait_done(dc);

    repeat (3) tick();
    chk("sb_leftover", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
